// File: rtl/cache_mem_arbiter_pkg.sv
// Shared definitions for the i_cache / d_cache memory-port arbiter:
// FSM state encodings, grant side encoding and the fixed I-fetch bus attributes.
package cache_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GNT_I   = 2'd1,
    ARB_GNT_D   = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_e;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } arb_side_e;

  // Instruction fetches are always full-word reads.
  localparam logic [1:0] IFETCH_SIZE = 2'b10;
  localparam logic [3:0] IFETCH_SEL  = 4'b1111;

  // Grant state that corresponds to a winning side.
  function automatic arb_state_e grant_state(input arb_side_e side);
    arb_state_e st;
    if (side == SIDE_D) begin
      st = ARB_GNT_D;
    end else begin
      st = ARB_GNT_I;
    end
    return st;
  endfunction

endpackage

// File: rtl/cache_mem_arbiter.sv
// Registered arbiter sharing the single-outstanding memory port between
// i_cache and d_cache. A grant is held for a whole transfer (until mem_ready),
// followed by one release cycle; simultaneous requests use a fixed priority
// with a starvation guard that hands the next grant to a side left waiting.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int D_FIRST    = 1,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_addr,
  input  logic        i_strobe,
  output logic        i_ready,
  input  logic [31:0] d_addr,
  input  logic        d_strobe,
  input  logic        d_rw,
  input  logic [1:0]  d_size,
  input  logic [3:0]  d_wen,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] mem_a,
  output logic        mem_access,
  output logic        mem_write,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_st_data,
  input  logic        mem_ready,
  output logic        grant_i,
  output logic        grant_d,
  output logic        busy
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam arb_side_e        PRIO_SIDE  = (D_FIRST != 0) ? SIDE_D : SIDE_I;

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  arb_side_e        last_q, last_d;

  logic             both_s;
  logic             override_s;
  arb_side_e        win_s;

  // Saturating increment of the starvation counter.
  function automatic logic [CNT_W-1:0] starve_inc(input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] nxt;
    if (cnt >= STARVE_LIM) begin
      nxt = STARVE_LIM;
    end else begin
      nxt = cnt + CNT_W'(1);
    end
    return nxt;
  endfunction

  // Pick the winner of an IDLE arbitration; the starved side wins once the counter saturates.
  always_comb begin
    both_s     = i_strobe & d_strobe;
    override_s = 1'b0;
    win_s      = PRIO_SIDE;
    if (both_s) begin
      if (starve_q == STARVE_LIM) begin
        override_s = 1'b1;
        win_s      = arb_side_e'(~last_q);
      end else begin
        win_s      = PRIO_SIDE;
      end
    end else if (i_strobe) begin
      win_s = SIDE_I;
    end else begin
      win_s = SIDE_D;
    end
  end

  // Next state, starvation counter and last-grant bookkeeping.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    last_d   = last_q;
    case (state_q)
      ARB_IDLE: begin
        if (i_strobe || d_strobe) begin
          state_d = grant_state(win_s);
          last_d  = win_s;
          if (override_s) begin
            starve_d = {CNT_W{1'b0}};
          end else if (both_s && (win_s == last_q)) begin
            starve_d = starve_inc(starve_q);
          end else begin
            starve_d = {CNT_W{1'b0}};
          end
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_GNT_I, ARB_GNT_D: begin
        // The grant is locked: strobes are ignored until the transfer completes.
        if (mem_ready) begin
          state_d = ARB_RELEASE;
        end else begin
          state_d = state_q;
        end
      end
      ARB_RELEASE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      starve_q <= {CNT_W{1'b0}};
      last_q   <= SIDE_D;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      last_q   <= last_d;
    end
  end

  // Memory-port mux driven only by the registered state and the grantee's fields.
  always_comb begin
    mem_a       = 32'h0000_0000;
    mem_access  = 1'b0;
    mem_write   = 1'b0;
    mem_size    = 2'b00;
    mem_sel     = 4'b0000;
    mem_st_data = 32'h0000_0000;
    case (state_q)
      ARB_GNT_I: begin
        mem_a       = i_addr;
        mem_access  = 1'b1;
        mem_write   = 1'b0;
        mem_size    = IFETCH_SIZE;
        mem_sel     = IFETCH_SEL;
        mem_st_data = 32'h0000_0000;
      end
      ARB_GNT_D: begin
        mem_a       = d_addr;
        mem_access  = 1'b1;
        mem_write   = d_rw;
        mem_size    = d_size;
        mem_sel     = d_wen;
        mem_st_data = d_wdata;
      end
      default: begin
        mem_access  = 1'b0;
      end
    endcase
  end

  // Grant flags, completion routing and busy; a ready pulse with no grant is dropped.
  always_comb begin
    grant_i = (state_q == ARB_GNT_I);
    grant_d = (state_q == ARB_GNT_D);
    busy    = (state_q != ARB_IDLE);
    i_ready = mem_ready & grant_i;
    d_ready = mem_ready & grant_d;
  end

endmodule
